// File: rtl/serial_fulladder.sv
// Bit-serial WIDTH-bit adder (one full-adder cell + carry flop, LSB first); done pulses WIDTH+1 cycles after an accepted start.
// Accepts start only in IDLE or in the DONE cycle; start while busy is dropped, not queued.
module serial_fulladder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MSB_IN_BIT = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             c_msb_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic             bit_d;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;

    // The single full-adder cell operating on the current LSBs.
    assign bit_d   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign res_d   = {bit_d, res_q[WIDTH-1:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Carry into the MSB is kept so overflow can be formed on the last step.
                    if (cnt_q == MSB_IN_BIT) begin
                        c_msb_q <= carry_d;
                    end
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        ovf_q   <= c_msb_q ^ carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign sum_o      = sum_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_fulladder.sv
// Directed and random checks of the bit-serial adder at WIDTH=8.
module tb_serial_fulladder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    int total = 0;
    int bad = 0;

    serial_fulladder #(.WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .a_i        (a),
        .b_i        (b),
        .cin_i      (cin),
        .busy_o     (busy),
        .done_o     (done),
        .sum_o      (sum),
        .cout_o     (cout),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs set and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string nm, input int cyc, input logic eb, input logic ed);
        total++;
        if (busy !== eb || done !== ed) begin
            bad++;
            $display("FAIL %s cycle %0d: busy=%0b done=%0b, required busy=%0b done=%0b", nm, cyc, busy, done, eb, ed);
        end
    endtask

    task automatic chk_res(input string nm, input logic [7:0] es, input logic ec, input logic eo);
        total++;
        if (sum !== es || cout !== ec || overflow !== eo) begin
            bad++;
            $display("FAIL %s: sum=%02h cout=%0b ovf=%0b, required sum=%02h cout=%0b ovf=%0b",
                     nm, sum, cout, overflow, es, ec, eo);
        end
    endtask

    // Start in cycle 0, check busy cycles 1..8, done in 9, quiet in 10.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input logic [7:0] es, input logic ec, input logic eo, input string nm);
        logic [7:0] prev_s;
        logic       prev_c;
        logic       prev_o;
        prev_s = sum;
        prev_c = cout;
        prev_o = overflow;
        a = av; b = bv; cin = cv; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        for (int i = 1; i <= 8; i++) begin
            chk_flags(nm, i, 1'b1, 1'b0);
            if (i == 4) chk_res({nm, " hold"}, prev_s, prev_c, prev_o);
            tick();
        end
        chk_flags(nm, 9, 1'b0, 1'b1);
        chk_res(nm, es, ec, eo);
        tick();
        chk_flags(nm, 10, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_flags("reset", 0, 1'b0, 1'b0);
        chk_res("reset", 8'h00, 1'b0, 1'b0);
        tick();
        chk_flags("reset idle", 1, 1'b0, 1'b0);
    endtask

    task automatic test_basic();
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "basic 0f+01");
    endtask

    task automatic test_carry_overflow();
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff+01");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f+01");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "80+80");
        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, "00+ff+1");
        run_op(8'h40, 8'h3F, 1'b1, 8'h80, 1'b0, 1'b1, "40+3f+1");
    endtask

    task automatic test_ignore_start();
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        tick();
        start = 1'b0;
        for (int i = 4; i < 9; i++) tick();
        chk_flags("ignore start", 9, 1'b0, 1'b1);
        chk_res("ignore start", 8'h46, 1'b0, 1'b0);
        for (int i = 10; i < 21; i++) begin
            tick();
            chk_flags("ignore start quiet", i, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        a = 8'h55; b = 8'h0A; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 9; i++) tick();
        chk_flags("b2b first", 9, 1'b0, 1'b1);
        chk_res("b2b first", 8'h5F, 1'b0, 1'b0);
        a = 8'h01; b = 8'h02; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 10; i < 18; i++) begin
            chk_flags("b2b second busy", i, 1'b1, 1'b0);
            chk_res("b2b hold", 8'h5F, 1'b0, 1'b0);
            tick();
        end
        chk_flags("b2b second", 18, 1'b0, 1'b1);
        chk_res("b2b second", 8'h03, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_abort();
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 4; i++) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk_flags("abort", 5, 1'b0, 1'b0);
        chk_res("abort", 8'h00, 1'b0, 1'b0);
        a = 8'h21; b = 8'h42; cin = 1'b1;
        tick();
        chk_flags("abort idle", 6, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 7; i < 15; i++) begin
            chk_flags("restart busy", i, 1'b1, 1'b0);
            tick();
        end
        chk_flags("restart", 15, 1'b0, 1'b1);
        chk_res("restart", 8'h64, 1'b0, 1'b0);
        tick();
        chk_flags("restart quiet", 16, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] av;
        logic [7:0] bv;
        logic       cv;
        logic [8:0] full;
        logic       ov;
        for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            cv = 1'($urandom);
            full = {1'b0, av} + {1'b0, bv} + {8'h00, cv};
            ov = (av[7] == bv[7]) && (full[7] != av[7]);
            run_op(av, bv, cv, full[7:0], full[8], ov, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
